// File: rtl/gates_selftest_if.sv
// Signal bundle between the gate-stage self-test sequencer and its environment:
// run control/status plus the stimulus and results of the gate block under test.
interface gates_selftest_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             a, b, c;
    logic             and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       first_fail_vec;
    logic [6:0]       first_fail_mask;

    modport master (
        output start, and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
        input  a, b, c, busy, done, pass, err_count, first_fail_vec, first_fail_mask
    );

    modport slave (
        input  start, and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
        output a, b, c, busy, done, pass, err_count, first_fail_vec, first_fail_mask
    );
endinterface

// File: rtl/gates_selftest.sv
// Bring-up checker for the logic-gate stage: walks the 8 {a,b,c} vectors, waits
// SETTLE_CYCLES per vector, compares all seven gate outputs and reports the result.
module gates_selftest #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    gates_selftest_if.slave  bus
);
    localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t           state, state_d;
    logic             armed;
    logic [2:0]       vec;
    logic [SW-1:0]    settle_cnt;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       ff_vec;
    logic [6:0]       ff_mask;
    logic             done, pass;
    logic             launch, check;
    logic [6:0]       expected, actual, mask;

    // Bit order {and, or, not, nand, nor, xor, xnor}; c (vec[0]) is deliberately unused.
    always_comb begin
        expected = {vec[2] & vec[1], vec[2] | vec[1], ~vec[2], ~(vec[2] & vec[1]),
                    ~(vec[2] | vec[1]), vec[2] ^ vec[1], ~(vec[2] ^ vec[1])};
        actual   = {bus.and_out, bus.or_out, bus.not_out, bus.nand_out,
                    bus.nor_out, bus.xor_out, bus.xnor_out};
        mask     = actual ^ expected;
    end

    // armed blocks a start that coincides with the first edge after reset release.
    always_comb begin
        state_d = state;
        launch  = 1'b0;
        check   = 1'b0;
        case (state)
            IDLE, DONE: if (bus.start && armed) begin
                launch  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: if (settle_cnt == '0) state_d = CHECK;
            CHECK: begin
                check   = 1'b1;
                state_d = (vec == 3'd7) ? DONE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_d;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            ff_vec     <= '0;
            ff_mask    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (launch) begin
            vec        <= '0;
            settle_cnt <= SETTLE_LOAD;
            err_count  <= '0;
            ff_vec     <= '0;
            ff_mask    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (state == SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end else if (check) begin
            if (mask != '0) begin
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                // err_count is still zero only before the first failing vector.
                if (err_count == '0) begin
                    ff_vec  <= vec;
                    ff_mask <= mask;
                end
            end
            if (vec == 3'd7) begin
                done <= 1'b1;
                pass <= (err_count == '0) && (mask == '0);
            end else begin
                vec        <= vec + 3'd1;
                settle_cnt <= SETTLE_LOAD;
            end
        end
    end

    assign bus.a               = vec[2];
    assign bus.b               = vec[1];
    assign bus.c               = vec[0];
    assign bus.busy            = (state == SETTLE) || (state == CHECK);
    assign bus.done            = done;
    assign bus.pass            = pass;
    assign bus.err_count       = err_count;
    assign bus.first_fail_vec  = ff_vec;
    assign bus.first_fail_mask = ff_mask;
endmodule

// File: tb/tb_gates_selftest.sv
// Bench for gates_selftest: a faultable gate-block model feeds two sequencer instances
// (defaults, and SETTLE_CYCLES=1/ERR_W=2); table-driven runs plus corner sequences.
module tb_gates_selftest;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gates_selftest_if #(.ERR_W(4)) m ();
    gates_selftest_if #(.ERR_W(2)) s ();

    gates_selftest #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m));
    gates_selftest #(.SETTLE_CYCLES(1), .ERR_W(2)) u_s1  (.clk(clk), .rst_n(rst_n), .bus(s));

    int fault_m = 0;
    int fault_s = 0;
    int checks  = 0;
    int errors  = 0;

    // Gate block model. Faults: 1 and stuck0, 2 xor/xnor swapped, 3 or stuck1,
    // 4 not stuck0, 5 c leaking into xor.
    always_comb begin
        m.and_out  = m.a & m.b;     m.or_out  = m.a | m.b;     m.not_out = ~m.a;
        m.nand_out = ~(m.a & m.b);  m.nor_out = ~(m.a | m.b);
        m.xor_out  = m.a ^ m.b;     m.xnor_out = ~(m.a ^ m.b);
        case (fault_m)
            1: m.and_out = 1'b0;
            2: begin m.xor_out = ~(m.a ^ m.b); m.xnor_out = m.a ^ m.b; end
            3: m.or_out = 1'b1;
            4: m.not_out = 1'b0;
            5: m.xor_out = m.a ^ m.b ^ m.c;
            default: ;
        endcase
    end

    always_comb begin
        s.and_out  = s.a & s.b;     s.or_out  = s.a | s.b;     s.not_out = ~s.a;
        s.nand_out = ~(s.a & s.b);  s.nor_out = ~(s.a | s.b);
        s.xor_out  = s.a ^ s.b;     s.xnor_out = ~(s.a ^ s.b);
        if (fault_s == 2) begin
            s.xor_out  = ~(s.a ^ s.b);
            s.xnor_out = s.a ^ s.b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_m(output int n);
        n = 0;
        while (!m.done && n < 200) begin tick(); n++; end
    endtask

    task automatic wait_s(output int n);
        n = 0;
        while (!s.done && n < 200) begin tick(); n++; end
    endtask

    task automatic chk_reset_m(input string tag);
        chk({tag, " busy"}, 32'(m.busy), 0);
        chk({tag, " done"}, 32'(m.done), 0);
        chk({tag, " pass"}, 32'(m.pass), 0);
        chk({tag, " err"},  32'(m.err_count), 0);
        chk({tag, " ffv"},  32'(m.first_fail_vec), 0);
        chk({tag, " ffm"},  32'(m.first_fail_mask), 0);
        chk({tag, " abc"},  32'({m.a, m.b, m.c}), 0);
    endtask

    typedef struct {
        int         fault;
        int         err;
        logic [2:0] ffv;
        logic [6:0] ffm;
        logic       pass;
    } vec_t;

    vec_t tbl[6];
    int   n;

    initial begin
        tbl[0] = '{0, 0, 3'd0, 7'b0000000, 1'b1};
        tbl[1] = '{1, 2, 3'd6, 7'b1000000, 1'b0};
        tbl[2] = '{2, 8, 3'd0, 7'b0000011, 1'b0};
        tbl[3] = '{3, 2, 3'd0, 7'b0100000, 1'b0};
        tbl[4] = '{4, 4, 3'd0, 7'b0010000, 1'b0};
        tbl[5] = '{5, 4, 3'd1, 7'b0000010, 1'b0};

        m.start = 1'b0;
        s.start = 1'b0;
        #2;
        chk_reset_m("reset");

        // start present on the first edge after reset release must be ignored
        #20;
        rst_n   = 1'b1;
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        chk("start at release busy", 32'(m.busy), 0);
        tick();
        chk("start at release idle", 32'(m.busy), 0);

        foreach (tbl[i]) begin
            fault_m = tbl[i].fault;
            m.start = 1'b1;
            tick();
            m.start = 1'b0;
            chk($sformatf("t%0d busy after E0", i), 32'(m.busy), 1);
            chk($sformatf("t%0d done after E0", i), 32'(m.done), 0);
            wait_m(n);
            chk($sformatf("t%0d done latency", i), n, 24);
            chk($sformatf("t%0d busy at done", i), 32'(m.busy), 0);
            chk($sformatf("t%0d pass", i), 32'(m.pass), 32'(tbl[i].pass));
            chk($sformatf("t%0d err_count", i), 32'(m.err_count), 32'(tbl[i].err));
            chk($sformatf("t%0d first_fail_vec", i), 32'(m.first_fail_vec), 32'(tbl[i].ffv));
            chk($sformatf("t%0d first_fail_mask", i), 32'(m.first_fail_mask), 32'(tbl[i].ffm));
        end

        // start held across a whole run: exactly one run
        fault_m = 1;
        m.start = 1'b1;
        tick();
        wait_m(n);
        m.start = 1'b0;
        chk("held done latency", n, 24);
        chk("held err", 32'(m.err_count), 2);
        tick();
        tick();
        chk("held done stays", 32'(m.done), 1);
        chk("held busy stays low", 32'(m.busy), 0);

        // restart from DONE clears everything on the same edge
        fault_m = 0;
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        chk("restart done drop", 32'(m.done), 0);
        chk("restart busy", 32'(m.busy), 1);
        chk("restart err clr", 32'(m.err_count), 0);
        chk("restart ffv clr", 32'(m.first_fail_vec), 0);
        chk("restart ffm clr", 32'(m.first_fail_mask), 0);
        chk("restart abc", 32'({m.a, m.b, m.c}), 0);
        wait_m(n);
        chk("restart latency", n, 24);
        chk("restart pass", 32'(m.pass), 1);

        // reset mid-run at vec 3 in SETTLE
        fault_m = 2;
        m.start = 1'b1;
        tick();
        m.start = 1'b0;
        repeat (9) tick();
        chk("midrun abc vec3", 32'({m.a, m.b, m.c}), 3);
        chk("midrun err before rst", 32'(m.err_count), 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_m("async rst");
        #1;
        rst_n = 1'b1;
        repeat (40) tick();
        chk("post rst no done", 32'(m.done), 0);
        chk("post rst idle", 32'(m.busy), 0);

        // SETTLE_CYCLES=1, ERR_W=2: saturating error count
        fault_s = 2;
        s.start = 1'b1;
        tick();
        s.start = 1'b0;
        wait_s(n);
        chk("s1 sat latency", n, 16);
        chk("s1 sat err", 32'(s.err_count), 3);
        chk("s1 sat ffv", 32'(s.first_fail_vec), 0);
        chk("s1 sat ffm", 32'(s.first_fail_mask), 32'(7'b0000011));
        chk("s1 sat pass", 32'(s.pass), 0);

        // SETTLE_CYCLES=1 correct block: stimulus moves only on CHECK->SETTLE edges
        fault_s = 0;
        s.start = 1'b1;
        tick();
        s.start = 1'b0;
        chk("s1 abc k0", 32'({s.a, s.b, s.c}), 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("s1 abc k%0d", k), 32'({s.a, s.b, s.c}), (k == 16) ? 7 : k / 2);
            chk($sformatf("s1 done k%0d", k), 32'(s.done), 32'(k == 16));
        end
        chk("s1 pass", 32'(s.pass), 1);
        chk("s1 err", 32'(s.err_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
